// File: rtl/rf_write_queue.sv
// rf_write_queue: buffered writer for the single write port of an 8-entry register file.
// Write-back requests (register index + data) enter through a valid/ready handshake and
// are held in a circular FIFO. Entries drain one per cycle, in arrival order, onto
// writeRegSel/writeData/writeEn. A per-register pending mask flags un-retired writes.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   enq_valid       request presented
//   enq_reg         destination register index (3 bits)
//   enq_data        value to write (WIDTH bits)
//   enq_ready       queue can accept a request this cycle (not full)
//   drain_stall     hold the head entry, suppress the register-file write
//   writeRegSel     head entry index (0 when empty)
//   writeData       head entry data (0 when empty)
//   writeEn         head entry is written at this edge
//   pending         bit r set while any valid entry targets register r
//   count           number of valid entries
//   err             overflow attempt or X on any input
module rf_write_queue #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  input  logic [2:0]                 enq_reg,
  input  logic [WIDTH-1:0]           enq_data,
  output logic                       enq_ready,
  input  logic                       drain_stall,
  output logic [2:0]                 writeRegSel,
  output logic [WIDTH-1:0]           writeData,
  output logic                       writeEn,
  output logic [7:0]                 pending,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW:0] CountFull = DEPTH[AddrW:0];

  logic [AddrW-1:0] head_q, tail_q;
  logic [AddrW:0]   count_q, count_d;

  // Entry storage carries no reset; validity comes from head/count alone.
  logic [2:0]       reg_mem  [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];

  logic enq_fire, deq_fire, not_empty;

  assign not_empty = (count_q != '0);
  assign enq_ready = (count_q != CountFull);
  assign enq_fire  = enq_valid & enq_ready & ~rst;
  // Reset cycles never write the register file.
  assign writeEn   = not_empty & ~drain_stall & ~rst;
  assign deq_fire  = writeEn;
  assign count     = count_q;

  assign writeRegSel = not_empty ? reg_mem[head_q]  : '0;
  assign writeData   = not_empty ? data_mem[head_q] : '0;

  always_comb begin
    count_d = count_q;
    unique case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) tail_q <= tail_q + 1'b1;
      if (deq_fire) head_q <= head_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      reg_mem[tail_q]  <= enq_reg;
      data_mem[tail_q] <= enq_data;
    end
  end

  // Walk the valid window starting at head; the head stays pending through its write cycle.
  always_comb begin
    logic [AddrW-1:0] idx;
    pending = '0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + AddrW'(i);
      if ((AddrW+1)'(i) < count_q) pending[reg_mem[idx]] = 1'b1;
    end
  end

  logic x_seen;
  assign x_seen = ((^{clk, rst, enq_valid, enq_reg, enq_data, drain_stall}) === 1'bx);
  assign err    = (enq_valid & ~enq_ready) | x_seen;

endmodule

// File: tb/tb_rf_write_queue.sv
module tb_rf_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic [2:0]  enq_reg;
  logic [15:0] enq_data;
  logic        enq_ready;
  logic        drain_stall;
  logic [2:0]  writeRegSel;
  logic [15:0] writeData;
  logic        writeEn;
  logic [7:0]  pending;
  logic [2:0]  count;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [18:0] wlog[$];   // {reg, data} of every register-file write
  logic [18:0] expq[$];   // model FIFO for the wrap-around section
  logic [18:0] sent_q[$]; // everything accepted in the wrap-around section

  rf_write_queue #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_reg(enq_reg), .enq_data(enq_data),
    .enq_ready(enq_ready), .drain_stall(drain_stall), .writeRegSel(writeRegSel),
    .writeData(writeData), .writeEn(writeEn), .pending(pending), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (writeEn) wlog.push_back({writeRegSel, writeData});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [2:0] r, input logic [15:0] d);
    enq_valid = 1'b1;
    enq_reg   = r;
    enq_data  = d;
  endtask

  initial begin
    int mcount, sent, retired, cyc;
    logic ev, st, mwe;
    logic [18:0] item;

    rst = 1'b1; enq_valid = 1'b0; enq_reg = '0; enq_data = '0; drain_stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_ready", enq_ready, 1);
    check("rst_wen", writeEn, 0);
    check("rst_sel", writeRegSel, 0);
    check("rst_data", writeData, 0);
    check("rst_pending", pending, 8'h00);
    check("rst_err", err, 0);

    // Single write
    tick();
    enq(3'd3, 16'h1234);
    #1;
    check("sw_pend_same_cycle", pending, 8'h00);
    tick();
    enq_valid = 1'b0;
    #1;
    check("sw_wen", writeEn, 1);
    check("sw_sel", writeRegSel, 3);
    check("sw_data", writeData, 16'h1234);
    check("sw_pending", pending, 8'h08);
    check("sw_count", count, 1);
    tick();
    #1;
    check("sw_wen_after", writeEn, 0);
    check("sw_pending_after", pending, 8'h00);
    check("sw_count_after", count, 0);

    // Full / overflow
    wlog.delete();
    drain_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      enq(3'(i), 16'(i));
      tick();
    end
    enq_valid = 1'b0;
    #1;
    check("full_count", count, 4);
    check("full_ready", enq_ready, 0);
    check("full_wen_stalled", writeEn, 0);
    check("full_head_data", writeData, 16'h0001);
    check("full_pending", pending, 8'h1E);
    check("full_err_idle", err, 0);
    enq(3'd7, 16'hFFFF);
    #1;
    check("ovf_err", err, 1);
    tick();
    enq_valid = 1'b0;
    #1;
    check("ovf_count", count, 4);
    check("ovf_pending", pending, 8'h1E);
    drain_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("drain_wen", writeEn, 1);
      check("drain_sel", writeRegSel, i);
      check("drain_data", writeData, i);
      tick();
    end
    #1;
    check("drain_count", count, 0);
    check("drain_nwrites", wlog.size(), 4);

    // Simultaneous enqueue and dequeue at count 2
    drain_stall = 1'b1;
    enq(3'd2, 16'h0A22); tick();
    enq(3'd4, 16'h0B44); tick();
    drain_stall = 1'b0;
    enq(3'd6, 16'hBEEF);
    #1;
    check("sim_count2", count, 2);
    check("sim_wen", writeEn, 1);
    check("sim_sel", writeRegSel, 2);
    tick();
    enq_valid = 1'b0;
    #1;
    check("sim_count_hold", count, 2);
    check("sim_sel_next", writeRegSel, 4);
    tick();
    #1;
    check("sim_r6_sel", writeRegSel, 6);
    check("sim_r6_data", writeData, 16'hBEEF);
    check("sim_r6_count", count, 1);
    tick();
    #1;
    check("sim_empty", count, 0);

    // Same-register ordering
    enq(3'd5, 16'hAAAA); tick();
    enq(3'd5, 16'h5555);
    #1;
    check("same_first", writeData, 16'hAAAA);
    check("same_pend1", pending, 8'h20);
    tick();
    enq_valid = 1'b0;
    #1;
    check("same_second", writeData, 16'h5555);
    check("same_pend2", pending, 8'h20);
    check("same_count", count, 1);
    tick();
    #1;
    check("same_pend_clear", pending, 8'h00);
    check("same_wen_off", writeEn, 0);

    // Reset mid-operation
    drain_stall = 1'b1;
    enq(3'd1, 16'h0011); tick();
    enq(3'd2, 16'h0022); tick();
    enq(3'd3, 16'h0033); tick();
    wlog.delete();
    check("mid_count3", count, 3);
    drain_stall = 1'b0;
    rst = 1'b1;
    enq(3'd0, 16'h0099);
    #1;
    check("mid_wen_in_reset", writeEn, 0);
    tick();
    rst = 1'b0;
    enq_valid = 1'b0;
    #1;
    check("mid_count", count, 0);
    check("mid_pending", pending, 8'h00);
    check("mid_wen", writeEn, 0);
    tick(); tick();
    check("mid_no_writes", wlog.size(), 0);

    // Wrap-around with random stalls against a model FIFO
    wlog.delete();
    mcount = 0; sent = 0; retired = 0; cyc = 0;
    while (retired < 10 && cyc < 300) begin
      ev = (sent < 10) && ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 2) == 0);
      enq_valid   = ev;
      enq_reg     = 3'(sent % 8);
      enq_data    = 16'hC000 + 16'(sent);
      drain_stall = st;
      #1;
      mwe = (mcount != 0) && !st;
      check("wrap_count", count, mcount);
      check("wrap_ready", enq_ready, (mcount != 4));
      check("wrap_wen", writeEn, mwe);
      if (mwe) begin
        check("wrap_port", {writeRegSel, writeData}, expq[0]);
        void'(expq.pop_front());
        retired++;
        mcount--;
      end
      if (ev && (count != 4 || mwe) && (mcount + (mwe ? 1 : 0)) != 4) begin
        expq.push_back({enq_reg, enq_data});
        sent_q.push_back({enq_reg, enq_data});
        sent++;
        mcount++;
      end
      tick();
      cyc++;
    end
    enq_valid = 1'b0;
    drain_stall = 1'b0;
    check("wrap_done_in_budget", retired, 10);
    check("wrap_nwrites", wlog.size(), 10);
    for (int i = 0; i < 10 && i < wlog.size() && i < sent_q.size(); i++) begin
      item = sent_q[i];
      check("wrap_order", wlog[i], item);
    end
    #1;
    check("wrap_final_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
